// File: rtl/gray_timer_arbiter.sv
// Round-robin arbiter that lends one Gray-coded window timer to NREQ requesters.
// The winner owns the timer for its programmed length, then done/aborted pulses once.
module gray_timer_arbiter #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned CBITS = 11
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*CBITS-1:0]   len,
   output logic [NREQ-1:0]         grant,
   output logic [CBITS-1:0]        gray_cnt,
   output logic                    busy,
   output logic [NREQ-1:0]         done,
   output logic [NREQ-1:0]         aborted
);

   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_d;
   logic [CBITS-1:0]  cnt, cnt_d;
   logic [CBITS-1:0]  len_q, len_q_d;
   logic [CBITS-1:0]  term;
   logic [IW-1:0]     owner, owner_d;
   logic [IW-1:0]     last, last_d;
   logic [NREQ-1:0]   grant_d, done_d, aborted_d;
   logic              busy_d;
   logic [IW-1:0]     winner;
   logic [CBITS-1:0]  len_sel;
   logic              found;
   int unsigned       pos;

   function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
      onehot = NREQ'(1) << i;
   endfunction

   // len_q of zero wraps to all ones, giving a full 2^CBITS window
   assign term     = len_q - CBITS'(1);
   assign gray_cnt = cnt ^ (cnt >> 1);

   // Round-robin search starting just after the previous owner
   always_comb begin
      found   = 1'b0;
      winner  = '0;
      pos     = 0;
      len_sel = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         pos = (32'(last) + k) % NREQ;
         if (!found && req[IW'(pos)]) begin
            found  = 1'b1;
            winner = IW'(pos);
         end
      end
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (winner == IW'(i)) len_sel = len[i*CBITS +: CBITS];
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (found) state_d = RUN;
         RUN:     if (!req[owner] || cnt == term) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs and datapath
   always_comb begin
      grant_d   = grant;
      cnt_d     = cnt;
      len_q_d   = len_q;
      owner_d   = owner;
      last_d    = last;
      done_d    = '0;
      aborted_d = '0;
      busy_d    = (state_d != IDLE);
      case (state)
         IDLE: begin
            if (found) begin
               grant_d = onehot(winner);
               owner_d = winner;
               cnt_d   = '0;
               len_q_d = len_sel;
            end
         end
         RUN: begin
            if (!req[owner]) begin
               aborted_d = onehot(owner);
               grant_d   = '0;
               cnt_d     = '0;
            end else if (cnt == term) begin
               done_d  = onehot(owner);
               grant_d = '0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + CBITS'(1);
            end
         end
         DONE: begin
            grant_d = '0;
            last_d  = owner;
         end
         default: begin
            grant_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant   <= '0;
         done    <= '0;
         aborted <= '0;
         busy    <= 1'b0;
         cnt     <= '0;
         len_q   <= '0;
         owner   <= '0;
         last    <= IW'(NREQ - 1);
      end else begin
         grant   <= grant_d;
         done    <= done_d;
         aborted <= aborted_d;
         busy    <= busy_d;
         cnt     <= cnt_d;
         len_q   <= len_q_d;
         owner   <= owner_d;
         last    <= last_d;
      end
   end

endmodule

// File: tb/tb_gray_timer_arbiter.sv
// Directed bench for gray_timer_arbiter: single window, abort, max length,
// reset mid-run, round-robin order and late request.
module tb_gray_timer_arbiter;

   localparam int unsigned NREQ  = 4;
   localparam int unsigned CBITS = 11;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*CBITS-1:0] len;
   logic [NREQ-1:0]       grant;
   logic [CBITS-1:0]      gray_cnt;
   logic                  busy;
   logic [NREQ-1:0]       done;
   logic [NREQ-1:0]       aborted;

   int n_assert = 0;
   int n_fail   = 0;

   gray_timer_arbiter #(.NREQ(NREQ), .CBITS(CBITS)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .len      (len),
      .grant    (grant),
      .gray_cnt (gray_cnt),
      .busy     (busy),
      .done     (done),
      .aborted  (aborted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_len(input int i, input int v);
      len[i*CBITS +: CBITS] = CBITS'(v);
   endtask

   // grant, done, aborted, busy in one shot
   task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] d,
                          input logic [3:0] a, input logic b);
      chk({tag, " grant"},   32'(grant),   32'(g));
      chk({tag, " done"},    32'(done),    32'(d));
      chk({tag, " aborted"}, 32'(aborted), 32'(a));
      chk({tag, " busy"},    32'(busy),    32'(b));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [CBITS-1:0] prev;
      int               errs;
      logic [CBITS-1:0] iv;

      rst = 1'b1;
      req = '0;
      len = '0;
      tick();
      tick();
      chk_out("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      chk("reset gray", 32'(gray_cnt), 32'h0);
      rst = 1'b0;
      tick();
      chk_out("idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);

      // Single window, len0 = 3
      set_len(0, 3);
      req = 4'b0001;
      tick();
      chk_out("sw e0", 4'b0001, 4'b0000, 4'b0000, 1'b1);
      chk("sw gray0", 32'(gray_cnt), 32'h0);
      tick();
      chk("sw grant1", 32'(grant), 32'h1);
      chk("sw gray1", 32'(gray_cnt), 32'h1);
      tick();
      chk("sw grant2", 32'(grant), 32'h1);
      chk("sw gray2", 32'(gray_cnt), 32'h3);
      tick();
      chk_out("sw e3", 4'b0000, 4'b0001, 4'b0000, 1'b1);
      req = 4'b0000;
      tick();
      chk_out("sw e4", 4'b0000, 4'b0000, 4'b0000, 1'b0);

      // Abort: len1 = 10, drop req[1] after the 4th grant cycle
      set_len(1, 10);
      set_len(2, 2);
      req = 4'b0010;
      tick();
      chk("ab g1", 32'(grant), 32'h2);
      chk("ab gray1", 32'(gray_cnt), 32'h0);
      tick();
      chk("ab gray2", 32'(gray_cnt), 32'h1);
      tick();
      chk("ab gray3", 32'(gray_cnt), 32'h3);
      tick();
      chk("ab g4", 32'(grant), 32'h2);
      chk("ab gray4", 32'(gray_cnt), 32'h2);
      req = 4'b1101;
      tick();
      chk_out("ab pulse", 4'b0000, 4'b0000, 4'b0010, 1'b1);
      chk("ab gray reset", 32'(gray_cnt), 32'h0);
      tick();
      chk_out("ab idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tick();
      chk("ab next grant", 32'(grant), 32'h4);
      req = 4'b0100;
      tick();
      chk("ab next gray", 32'(gray_cnt), 32'h1);
      tick();
      chk_out("ab next done", 4'b0000, 4'b0100, 4'b0000, 1'b1);
      req = 4'b0000;
      tick();
      chk("ab back idle", 32'(busy), 32'h0);

      // Maximum length: len0 = 0 -> 2048 cycles
      set_len(0, 0);
      req = 4'b0001;
      tick();
      chk("max g0", 32'(grant), 32'h1);
      chk("max gray0", 32'(gray_cnt), 32'h0);
      prev = gray_cnt;
      errs = 0;
      for (int i = 1; i < 2048; i++) begin
         tick();
         iv = CBITS'(i);
         if (grant !== 4'b0001) errs++;
         if ($countones(gray_cnt ^ prev) != 1) errs++;
         if (gray_cnt !== (iv ^ (iv >> 1))) errs++;
         prev = gray_cnt;
      end
      chk("max window errs", 32'(errs), 32'h0);
      chk("max final gray", 32'(gray_cnt), 32'h400);
      tick();
      chk_out("max end", 4'b0000, 4'b0001, 4'b0000, 1'b1);
      req = 4'b0000;
      tick();
      chk("max idle", 32'(busy), 32'h0);

      // Reset asserted between edges during RUN
      set_len(0, 5);
      req = 4'b0001;
      tick();
      tick();
      chk("rst pre gray", 32'(gray_cnt), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk_out("rst async", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      chk("rst async gray", 32'(gray_cnt), 32'h0);
      tick();
      chk_out("rst held", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      rst = 1'b0;

      // Round-robin after reset, all len = 1
      for (int i = 0; i < 4; i++) set_len(i, 1);
      req = 4'b1111;
      for (int w = 0; w < 5; w++) begin
         tick();
         chk_out($sformatf("rr%0d grant", w), 4'(1 << (w % 4)), 4'b0000, 4'b0000, 1'b1);
         tick();
         chk_out($sformatf("rr%0d done", w), 4'b0000, 4'(1 << (w % 4)), 4'b0000, 1'b1);
         if (w == 4) req = 4'b0000;
         tick();
         chk_out($sformatf("rr%0d gap", w), 4'b0000, 4'b0000, 4'b0000, 1'b0);
      end

      // Late request: req[3] early, req[2] raised during DONE of requester 0
      set_len(0, 2);
      set_len(2, 1);
      set_len(3, 1);
      req = 4'b0001;
      tick();
      chk("lr g0", 32'(grant), 32'h1);
      req = 4'b1001;
      set_len(0, 7);
      tick();
      chk("lr g0 gray", 32'(gray_cnt), 32'h1);
      tick();
      chk_out("lr done0", 4'b0000, 4'b0001, 4'b0000, 1'b1);
      req = 4'b1100;
      tick();
      chk_out("lr idle", 4'b0000, 4'b0000, 4'b0000, 1'b0);
      tick();
      chk("lr req2 wins", 32'(grant), 32'h4);
      tick();
      chk_out("lr done2", 4'b0000, 4'b0100, 4'b0000, 1'b1);
      req = 4'b1000;
      tick();
      tick();
      chk("lr req3", 32'(grant), 32'h8);
      tick();
      chk("lr done3", 32'(done), 32'h8);
      req = 4'b0000;
      tick();
      chk("lr final busy", 32'(busy), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_timer_arbiter.md
Name: gray_timer_arbiter

Overview:
Shares one Gray-coded window timer among NREQ requesters. Each requester asks for an exclusive timed window of a programmable length. A round-robin arbiter grants one requester at a time. The block runs the window on a binary counter, exposes the Gray-coded count to the granted client, and pulses done (or aborted) when the window closes. It sits in front of Gray-counter consumers, such as CDC pointers and sequenced sampling, that must never overlap.

Parameters:
NREQ, 4, number of requesters (≥2)
CBITS, 11, counter width; maximum window 2^CBITS cycles

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
req  input  NREQ  level request per requester; must stay high for the whole window
len  input  NREQ*CBITS  window length per requester; slice i = len[i*CBITS +: CBITS]; 0 means 2^CBITS
grant  output  NREQ  one-hot ownership of the timer; all zero when not owned
gray_cnt  output  CBITS  Gray code of internal count, cnt ^ (cnt>>1); meaningful only while grant != 0
busy  output  1  high in RUN and DONE
done  output  NREQ  one-cycle pulse on the owner bit when its window completes normally
aborted  output  NREQ  one-cycle pulse on the owner bit when its window ends early

Behaviour:
- Clock and reset: clk, rst. Reset is asynchronous, active-high.
- Reset values: state=IDLE; grant=0, done=0, aborted=0, busy=0, cnt=0 (so gray_cnt=0); owner=0; last=NREQ-1 (so requester 0 has first priority).
- State machine has three states: IDLE, RUN, DONE. All outputs except gray_cnt are registered. gray_cnt is combinational from cnt.
- IDLE:
  - If req != 0 at a rising edge, the winner is the first set bit searching last+1, last+2, …, wrapping modulo NREQ.
  - On that edge: state<=RUN, grant<=onehot(winner), owner<=winner, cnt<=0, len_q<=winner's len slice.
  - If req == 0, stay in IDLE.
- RUN, evaluated at each edge in priority order:
  1. req[owner]==0: state<=DONE, aborted[owner]<=1.
  2. cnt == len_q-1 (len_q=0 means terminal count is all ones): state<=DONE, done[owner]<=1.
  3. Otherwise cnt<=cnt+1. The increment never wraps inside a window.
  - On both exits: grant<=0 and cnt<=0 at the same edge.
- Window length: grant is high for exactly L cycles (L=len_q, or 2^CBITS if len_q=0). During those cycles gray_cnt steps through Gray(0)…Gray(L-1). Each step changes exactly one bit.
- DONE: lasts one cycle, with done/aborted pulsing and grant=0. Then state<=IDLE, last<=owner, and the pulses clear.
- Re-grant timing:
  - New requests are ignored in RUN and DONE.
  - Earliest re-grant: grant rises 2 cycles after the done pulse cycle (DONE, then IDLE, then grant).
  - Turnaround between back-to-back windows is therefore 2 idle grant cycles.
- len changes after latching do not affect the running window.
- A req rise and fall within one non-IDLE period is never granted; requests are level, not latched.
- Fairness: with all requesters continuously requesting, every requester is granted within NREQ windows.
- Reset asserted mid-RUN: all outputs clear immediately (asynchronously). No done or aborted pulse is issued for the interrupted window.

Test Plan:
- Single window: len0=3; req=0001 rises before edge 0.
  - grant=0001 after edges 0–2.
  - gray_cnt=0,1,3.
  - done=0001 for one cycle after edge 3; busy low after edge 4.
- Round-robin: req=1111 held, all len=1.
  - Grant order 0001,0010,0100,1000,0001.
  - Each grant lasts 1 cycle, spaced 3 cycles apart.
  - done pulses track the same order.
- Abort: len1=10; drop req[1] after the 4th grant cycle.
  - aborted=0010 pulses next cycle; done stays 0.
  - Then grant goes to the next requester in round-robin order.
- Maximum length: len0=0.
  - grant high exactly 2048 cycles.
  - Final gray_cnt=0x400 (Gray of 2047).
  - Successive gray_cnt values differ by exactly one bit throughout.
- Reset mid-run: assert rst between clock edges during RUN.
  - grant, busy and gray_cnt go to 0 before the next edge.
  - After release, requester 0 wins first when req=1111.
- Late request: raise req[2] during DONE of requester 0.
  - Not granted until the IDLE edge.
  - Then req[2] wins over req[3], even though req[3] was raised earlier.
